syn_acortex2fgyrus_bridge: RTL and testbench



---
 rtl/syn_acortex2fgyrus_pkg.sv | 22 ++
 rtl/syn_acortex2fgyrus_bridge_if.sv | 43 ++++
 rtl/syn_i2s_rx.sv | 76 +++++++
 rtl/syn_acortex2fgyrus_bridge.sv | 142 ++++++++++++++
 tb/tb_syn_acortex2fgyrus_bridge.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/syn_acortex2fgyrus_pkg.sv
// Shared constants for the ADC-to-fgyrus capture bridge: register map, bit positions and
// default parameter values.
package syn_acortex2fgyrus_pkg;

   localparam int unsigned DefPcmW       = 32;
   localparam int unsigned DefNumSamples = 128;
   localparam int unsigned DefPcmAddrW   = 7;
   localparam int unsigned DefMmAddrW    = 8;

   // Low two bits of the Avalon word address; higher bits must be zero to hit a register.
   typedef enum logic [1:0] {
      RegCtrl     = 2'd0,
      RegStatus   = 2'd1,
      RegFrameCnt = 2'd2,
      RegFill     = 2'd3
   } reg_addr_e;

   localparam int unsigned CtrlEnableBit   = 0;
   localparam int unsigned StatusWrBankBit = 0;
   localparam int unsigned StatusRdBankBit = 1;

endpackage

// File: rtl/syn_acortex2fgyrus_bridge_if.sv
// Bus bundle of the capture bridge: Avalon-MM control slave plus the two fgyrus sample
// read ports. The bridge sits on the slave side.
interface syn_acortex2fgyrus_bridge_if
   import syn_acortex2fgyrus_pkg::*;
#(
   parameter int unsigned MM_ADDR_W  = DefMmAddrW,
   parameter int unsigned PCM_ADDR_W = DefPcmAddrW
);

   logic                  av_read_ih;
   logic                  av_write_ih;
   logic [MM_ADDR_W-1:0]  av_addr_id;
   logic [31:0]           av_write_data_id;
   logic                  av_wait_req_oh;
   logic [31:0]           av_read_data_od;
   logic                  av_read_data_valid_oh;
   logic                  pcm_rdy_oh;
   logic                  lchnl_pcm_rd_ih;
   logic [PCM_ADDR_W-1:0] lchnl_pcm_addr_id;
   logic [31:0]           lchnl_pcm_data_od;
   logic                  lchnl_pcm_data_valid_oh;
   logic                  rchnl_pcm_rd_ih;
   logic [PCM_ADDR_W-1:0] rchnl_pcm_addr_id;
   logic [31:0]           rchnl_pcm_data_od;
   logic                  rchnl_pcm_data_valid_oh;

   modport slave (
      input  av_read_ih, av_write_ih, av_addr_id, av_write_data_id,
      input  lchnl_pcm_rd_ih, lchnl_pcm_addr_id, rchnl_pcm_rd_ih, rchnl_pcm_addr_id,
      output av_wait_req_oh, av_read_data_od, av_read_data_valid_oh, pcm_rdy_oh,
      output lchnl_pcm_data_od, lchnl_pcm_data_valid_oh,
      output rchnl_pcm_data_od, rchnl_pcm_data_valid_oh
   );

   modport master (
      output av_read_ih, av_write_ih, av_addr_id, av_write_data_id,
      output lchnl_pcm_rd_ih, lchnl_pcm_addr_id, rchnl_pcm_rd_ih, rchnl_pcm_addr_id,
      input  av_wait_req_oh, av_read_data_od, av_read_data_valid_oh, pcm_rdy_oh,
      input  lchnl_pcm_data_od, lchnl_pcm_data_valid_oh,
      input  rchnl_pcm_data_od, rchnl_pcm_data_valid_oh
   );

endinterface

// File: rtl/syn_i2s_rx.sv
// I2S receiver: synchronizes the codec pins into clk_ir, detects bclk rises and deserializes
// left-justified words, emitting one commit pulse per finished slot.
module syn_i2s_rx
   import syn_acortex2fgyrus_pkg::*;
#(
   parameter int unsigned PCM_W = DefPcmW
) (
   input  logic        clk_ir,
   input  logic        rst_il,
   input  logic        bclk,
   input  logic        lrc,
   input  logic        dat,
   output logic [31:0] sample,
   output logic        chnl,
   output logic        commit
);

   logic [1:0]  bclk_sync_q, lrc_sync_q, dat_sync_q;
   logic        bclk_prev_q;
   logic        lrc_prev_q;
   logic        word_chnl_q;
   logic [31:0] word_q;
   logic [5:0]  cnt_q;
   logic [31:0] sample_q;
   logic        chnl_q;
   logic        commit_q;
   logic        bclk_rise;
   logic [4:0]  pos;

   assign bclk_rise = bclk_sync_q[1] & ~bclk_prev_q;
   assign pos       = 5'(6'd31 - cnt_q);

   // Reset looks like the tail of a right slot, so the first left word after reset is a
   // proper word boundary.
   always_ff @(posedge clk_ir) begin
      if (!rst_il) begin
         bclk_sync_q <= '0;
         lrc_sync_q  <= '1;
         dat_sync_q  <= '0;
         bclk_prev_q <= 1'b0;
         lrc_prev_q  <= 1'b1;
         word_chnl_q <= 1'b1;
         word_q      <= '0;
         cnt_q       <= '0;
         sample_q    <= '0;
         chnl_q      <= 1'b0;
         commit_q    <= 1'b0;
      end else begin
         bclk_sync_q <= {bclk_sync_q[0], bclk};
         lrc_sync_q  <= {lrc_sync_q[0], lrc};
         dat_sync_q  <= {dat_sync_q[0], dat};
         bclk_prev_q <= bclk_sync_q[1];
         commit_q    <= 1'b0;
         if (bclk_rise) begin
            lrc_prev_q <= lrc_sync_q[1];
            // Bit belongs to lrc_prev_q; a change there closes the old channel's word.
            if (lrc_prev_q != word_chnl_q) begin
               commit_q    <= 1'b1;
               sample_q    <= word_q;
               chnl_q      <= word_chnl_q;
               word_chnl_q <= lrc_prev_q;
               word_q      <= {dat_sync_q[1], 31'b0};
               cnt_q       <= 6'd1;
            end else if (cnt_q < 6'(PCM_W)) begin
               word_q[pos] <= dat_sync_q[1];
               cnt_q       <= cnt_q + 6'd1;
            end
         end
      end
   end

   assign sample = sample_q;
   assign chnl   = chnl_q;
   assign commit = commit_q;

endmodule

// File: rtl/syn_acortex2fgyrus_bridge.sv
// Audio capture bridge: I2S ADC samples into per-channel ping-pong buffers read by fgyrus,
// with an Avalon-MM control/status register file.
module syn_acortex2fgyrus_bridge
   import syn_acortex2fgyrus_pkg::*;
#(
   parameter int unsigned PCM_W       = DefPcmW,
   parameter int unsigned NUM_SAMPLES = DefNumSamples,
   parameter int unsigned PCM_ADDR_W  = DefPcmAddrW,
   parameter int unsigned MM_ADDR_W   = DefMmAddrW
) (
   input  logic                         clk_ir,
   input  logic                         rst_il,
   input  logic                         aud_bclk_ir,
   input  logic                         aud_adc_lrc_ir,
   input  logic                         aud_adc_dat_id,
   syn_acortex2fgyrus_bridge_if.slave   bus
);

   logic [31:0]           sample;
   logic                  chnl;
   logic                  commit;
   logic                  enable_q, armed_q, wr_bank_q, rd_bank_q, pcm_rdy_q;
   logic [PCM_ADDR_W-1:0] wr_ptr_q;
   logic [31:0]           frame_cnt_q;
   logic [31:0]           mm_rdata_q;
   logic                  mm_rvalid_q;
   logic [31:0]           l_data_q, r_data_q;
   logic                  l_valid_q, r_valid_q;
   logic [31:0]           lram [2*NUM_SAMPLES];
   logic [31:0]           rram [2*NUM_SAMPLES];
   logic                  capture, l_we, r_we, swap;
   logic [PCM_ADDR_W:0]   wr_addr;
   logic                  mapped;
   reg_addr_e             reg_addr;
   logic                  wr_ctrl, wr_fcnt;
   logic [31:0]           rd_mux;
   logic                  unused_wdata;

   syn_i2s_rx #(
      .PCM_W (PCM_W)
   ) u_i2s_rx (
      .clk_ir (clk_ir),
      .rst_il (rst_il),
      .bclk   (aud_bclk_ir),
      .lrc    (aud_adc_lrc_ir),
      .dat    (aud_adc_dat_id),
      .sample (sample),
      .chnl   (chnl),
      .commit (commit)
   );

   assign capture = commit & enable_q & armed_q;
   assign l_we    = capture & ~chnl;
   assign r_we    = capture & chnl;
   assign swap    = r_we & (wr_ptr_q == PCM_ADDR_W'(NUM_SAMPLES - 1));
   assign wr_addr = {wr_bank_q, wr_ptr_q};

   assign mapped       = (bus.av_addr_id[MM_ADDR_W-1:2] == '0);
   assign reg_addr     = reg_addr_e'(bus.av_addr_id[1:0]);
   assign wr_ctrl      = bus.av_write_ih & mapped & (reg_addr == RegCtrl);
   assign wr_fcnt      = bus.av_write_ih & mapped & (reg_addr == RegFrameCnt);
   assign unused_wdata = ^bus.av_write_data_id[31:1];

   always_comb begin
      rd_mux = '0;
      if (mapped) begin
         case (reg_addr)
            RegCtrl:     rd_mux[CtrlEnableBit] = enable_q;
            RegStatus: begin
               rd_mux[StatusWrBankBit] = wr_bank_q;
               rd_mux[StatusRdBankBit] = rd_bank_q;
            end
            RegFrameCnt: rd_mux = frame_cnt_q;
            RegFill:     rd_mux = 32'(wr_ptr_q);
            default:     rd_mux = '0;
         endcase
      end
   end

   always_ff @(posedge clk_ir) begin
      if (!rst_il) begin
         enable_q    <= 1'b0;
         armed_q     <= 1'b0;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b1;
         wr_ptr_q    <= '0;
         pcm_rdy_q   <= 1'b0;
         frame_cnt_q <= '0;
         mm_rdata_q  <= '0;
         mm_rvalid_q <= 1'b0;
      end else begin
         pcm_rdy_q   <= swap;
         mm_rvalid_q <= bus.av_read_ih;
         if (bus.av_read_ih) mm_rdata_q <= rd_mux;
         if (wr_ctrl) enable_q <= bus.av_write_data_id[CtrlEnableBit];
         if (!enable_q) begin
            wr_ptr_q <= '0;
            armed_q  <= 1'b0;
         end else begin
            // A right-word commit marks the lrc_d 1->0 edge: the next word is a full left one.
            if (commit && chnl && !armed_q) armed_q <= 1'b1;
            if (r_we) wr_ptr_q <= wr_ptr_q + PCM_ADDR_W'(1);
            if (swap) begin
               wr_bank_q <= ~wr_bank_q;
               rd_bank_q <= wr_bank_q;
            end
         end
         if (wr_fcnt) frame_cnt_q <= '0;
         else if (swap) frame_cnt_q <= frame_cnt_q + 32'd1;
      end
   end

   // Sample storage is deliberately left out of reset.
   always_ff @(posedge clk_ir) begin
      if (l_we) lram[wr_addr] <= sample;
      if (r_we) rram[wr_addr] <= sample;
   end

   always_ff @(posedge clk_ir) begin
      if (!rst_il) begin
         l_data_q  <= '0;
         r_data_q  <= '0;
         l_valid_q <= 1'b0;
         r_valid_q <= 1'b0;
      end else begin
         l_valid_q <= bus.lchnl_pcm_rd_ih;
         r_valid_q <= bus.rchnl_pcm_rd_ih;
         if (bus.lchnl_pcm_rd_ih) l_data_q <= lram[{rd_bank_q, bus.lchnl_pcm_addr_id}];
         if (bus.rchnl_pcm_rd_ih) r_data_q <= rram[{rd_bank_q, bus.rchnl_pcm_addr_id}];
      end
   end

   assign bus.av_wait_req_oh          = 1'b0;
   assign bus.av_read_data_od         = mm_rdata_q;
   assign bus.av_read_data_valid_oh   = mm_rvalid_q;
   assign bus.pcm_rdy_oh              = pcm_rdy_q;
   assign bus.lchnl_pcm_data_od       = l_data_q;
   assign bus.lchnl_pcm_data_valid_oh = l_valid_q;
   assign bus.rchnl_pcm_data_od       = r_data_q;
   assign bus.rchnl_pcm_data_valid_oh = r_valid_q;

endmodule

// File: tb/tb_syn_acortex2fgyrus_bridge.sv
// Bench for the capture bridge: a 32-bit instance with 16-sample buffers and a 16-bit
// instance share one I2S stream; reads are checked through expectation queues.
module tb_syn_acortex2fgyrus_bridge;
   import syn_acortex2fgyrus_pkg::*;

   localparam int unsigned NS = 16;
   localparam int unsigned AW = 4;

   logic clk = 1'b0;
   logic rst_n, bclk, lrc, dat;

   always #5 clk = ~clk;

   syn_acortex2fgyrus_bridge_if #(.MM_ADDR_W(8), .PCM_ADDR_W(AW)) bus ();
   syn_acortex2fgyrus_bridge_if #(.MM_ADDR_W(8), .PCM_ADDR_W(AW)) bus16 ();

   syn_acortex2fgyrus_bridge #(
      .PCM_W(32), .NUM_SAMPLES(NS), .PCM_ADDR_W(AW), .MM_ADDR_W(8)
   ) dut (
      .clk_ir(clk), .rst_il(rst_n), .aud_bclk_ir(bclk), .aud_adc_lrc_ir(lrc),
      .aud_adc_dat_id(dat), .bus(bus)
   );

   syn_acortex2fgyrus_bridge #(
      .PCM_W(16), .NUM_SAMPLES(NS), .PCM_ADDR_W(AW), .MM_ADDR_W(8)
   ) dut16 (
      .clk_ir(clk), .rst_il(rst_n), .aud_bclk_ir(bclk), .aud_adc_lrc_ir(lrc),
      .aud_adc_dat_id(dat), .bus(bus16)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] mmq[$], lq[$], rq[$], lq16[$], rq16[$];
   logic [31:0] fl_q[$], fr_q[$];
   bit busy = 1'b0;
   int bit_idx = 0;
   int rdy_cnt = 0, rdy_hi = 0, rdy16_cnt = 0;
   bit rdy_prev = 1'b0, rdy16_prev = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // I2S source: lrc/dat change while bclk is low, one-bit delay after each lrc edge.
   initial begin
      logic [31:0] l, r;
      logic prev_lsb;
      bclk = 1'b0; lrc = 1'b1; dat = 1'b0; prev_lsb = 1'b0;
      forever begin
         if (fl_q.size() == 0) begin
            busy = 1'b0;
            #10;
         end else begin
            busy = 1'b1;
            l = fl_q.pop_front();
            r = fr_q.pop_front();
            for (int b = 0; b < 64; b++) begin
               bit_idx = b;
               bclk = 1'b0;
               lrc = (b >= 32);
               if (b == 0) dat = prev_lsb;
               else if (b <= 32) dat = l[32-b];
               else dat = r[64-b];
               #40 bclk = 1'b1;
               #40;
            end
            prev_lsb = r[0];
         end
      end
   end

   always @(negedge clk) begin
      if (bus.av_read_data_valid_oh) begin
         if (mmq.size() == 0) chk("mm_spurious", 1, 0);
         else chk("mm_rd", bus.av_read_data_od, mmq.pop_front());
      end
      if (bus.lchnl_pcm_data_valid_oh) begin
         if (lq.size() == 0) chk("l_spurious", 1, 0);
         else chk("lchnl_rd", bus.lchnl_pcm_data_od, lq.pop_front());
      end
      if (bus.rchnl_pcm_data_valid_oh) begin
         if (rq.size() == 0) chk("r_spurious", 1, 0);
         else chk("rchnl_rd", bus.rchnl_pcm_data_od, rq.pop_front());
      end
      if (bus16.lchnl_pcm_data_valid_oh) begin
         if (lq16.size() == 0) chk("l16_spurious", 1, 0);
         else chk("lchnl16_rd", bus16.lchnl_pcm_data_od, lq16.pop_front());
      end
      if (bus16.rchnl_pcm_data_valid_oh) begin
         if (rq16.size() == 0) chk("r16_spurious", 1, 0);
         else chk("rchnl16_rd", bus16.rchnl_pcm_data_od, rq16.pop_front());
      end
      if (bus.pcm_rdy_oh) begin
         rdy_hi++;
         if (!rdy_prev) rdy_cnt++;
      end
      if (bus16.pcm_rdy_oh && !rdy16_prev) rdy16_cnt++;
      rdy_prev = bus.pcm_rdy_oh;
      rdy16_prev = bus16.pcm_rdy_oh;
   end

   task automatic mm_access(input bit d16, input bit rd, input bit wr, input logic [7:0] a,
                            input logic [31:0] wdata, input logic [31:0] exp);
      @(posedge clk); #1;
      if (d16) begin
         bus16.av_read_ih = rd; bus16.av_write_ih = wr;
         bus16.av_addr_id = a;  bus16.av_write_data_id = wdata;
      end else begin
         bus.av_read_ih = rd; bus.av_write_ih = wr;
         bus.av_addr_id = a;  bus.av_write_data_id = wdata;
         if (rd) begin
            mmq.push_back(exp);
            chk("wait_req", {31'b0, bus.av_wait_req_oh}, 0);
         end
      end
      @(posedge clk); #1;
      bus.av_read_ih = 1'b0; bus.av_write_ih = 1'b0;
      bus16.av_read_ih = 1'b0; bus16.av_write_ih = 1'b0;
   endtask

   task automatic mm_read(input logic [7:0] a, input logic [31:0] exp);
      mm_access(1'b0, 1'b1, 1'b0, a, 32'h0, exp);
   endtask

   task automatic mm_write(input bit d16, input logic [7:0] a, input logic [31:0] wdata);
      mm_access(d16, 1'b0, 1'b1, a, wdata, 32'h0);
   endtask

   task automatic pcm_read(input bit d16, input bit right, input logic [AW-1:0] a,
                           input logic [31:0] exp);
      @(posedge clk); #1;
      case ({d16, right})
         2'b00: begin bus.lchnl_pcm_rd_ih = 1'b1; bus.lchnl_pcm_addr_id = a; lq.push_back(exp); end
         2'b01: begin bus.rchnl_pcm_rd_ih = 1'b1; bus.rchnl_pcm_addr_id = a; rq.push_back(exp); end
         2'b10: begin bus16.lchnl_pcm_rd_ih = 1'b1; bus16.lchnl_pcm_addr_id = a; lq16.push_back(exp); end
         default: begin bus16.rchnl_pcm_rd_ih = 1'b1; bus16.rchnl_pcm_addr_id = a; rq16.push_back(exp); end
      endcase
      @(posedge clk); #1;
      bus.lchnl_pcm_rd_ih = 1'b0; bus.rchnl_pcm_rd_ih = 1'b0;
      bus16.lchnl_pcm_rd_ih = 1'b0; bus16.rchnl_pcm_rd_ih = 1'b0;
   endtask

   task automatic push_frame(input logic [31:0] l, input logic [31:0] r);
      fl_q.push_back(l);
      fr_q.push_back(r);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((fl_q.size() != 0 || busy) && n < 40000) begin @(posedge clk); n++; end
      repeat (8) @(posedge clk);
   endtask

   task automatic wait_rdy(input bit d16, input int target, input string tag);
      int n = 0;
      while (((d16 ? rdy16_cnt : rdy_cnt) < target) && n < 20000) begin
         @(posedge clk);
         n++;
      end
      repeat (4) @(posedge clk);
      chk(tag, d16 ? rdy16_cnt : rdy_cnt, target);
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      bus.av_read_ih = 1'b0; bus.av_write_ih = 1'b0; bus.av_addr_id = '0;
      bus.av_write_data_id = '0; bus.lchnl_pcm_rd_ih = 1'b0; bus.lchnl_pcm_addr_id = '0;
      bus.rchnl_pcm_rd_ih = 1'b0; bus.rchnl_pcm_addr_id = '0;
      bus16.av_read_ih = 1'b0; bus16.av_write_ih = 1'b0; bus16.av_addr_id = '0;
      bus16.av_write_data_id = '0; bus16.lchnl_pcm_rd_ih = 1'b0; bus16.lchnl_pcm_addr_id = '0;
      bus16.rchnl_pcm_rd_ih = 1'b0; bus16.rchnl_pcm_addr_id = '0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("rst_rdata", bus.av_read_data_od, 0);
      chk("rst_rvalid", {31'b0, bus.av_read_data_valid_oh}, 0);
      chk("rst_waitreq", {31'b0, bus.av_wait_req_oh}, 0);
      chk("rst_rdy", {31'b0, bus.pcm_rdy_oh}, 0);
      chk("rst_ldata", bus.lchnl_pcm_data_od, 0);
      chk("rst_lvalid", {31'b0, bus.lchnl_pcm_data_valid_oh}, 0);
      chk("rst_rdata_r", bus.rchnl_pcm_data_od, 0);
      chk("rst_rvalid_r", {31'b0, bus.rchnl_pcm_data_valid_oh}, 0);
      @(posedge clk); #1 rst_n = 1'b1;

      mm_read(8'(RegCtrl), 32'h0);
      mm_read(8'h3F, 32'h0);
      mm_read(8'(RegStatus), 32'h2);
      mm_read(8'(RegFrameCnt), 32'h0);
      mm_write(1'b0, 8'(RegCtrl), 32'h1);

      // First buffer; frame 1000 is the start of the second batch and closes the 16th word.
      for (int i = 0; i < NS; i++) push_frame(i, 32'hFFFF0000 | i);
      push_frame(32'd1000, 32'hFFFF0000);
      wait_rdy(1'b0, 1, "rdy_first");
      pcm_read(1'b0, 1'b0, 4'd5, 32'd5);
      pcm_read(1'b0, 1'b1, 4'd15, 32'hFFFF000F);
      pcm_read(1'b0, 1'b0, 4'd0, 32'd0);
      mm_read(8'(RegFrameCnt), 32'd1);
      mm_read(8'(RegStatus), 32'h1);

      for (int i = 1; i < NS; i++) push_frame(1000 + i, 32'hFFFF0000 | i);
      push_frame(32'd2000, 32'h00002000);
      wait_rdy(1'b0, 2, "rdy_second");
      pcm_read(1'b0, 1'b0, 4'd0, 32'd1000);
      pcm_read(1'b0, 1'b0, 4'd15, 32'd1015);
      mm_read(8'(RegFrameCnt), 32'd2);
      mm_read(8'(RegStatus), 32'h2);

      // Partial third buffer, then disable.
      for (int i = 1; i < 6; i++) push_frame(2000 + i, 32'h00002000 | i);
      wait_idle();
      mm_read(8'(RegFill), 32'd5);
      mm_write(1'b0, 8'(RegCtrl), 32'h0);
      mm_read(8'(RegFill), 32'd0);
      mm_read(8'(RegStatus), 32'h2);
      mm_read(8'(RegCtrl), 32'h0);

      // Re-enable in the middle of a right slot; that right word must be dropped.
      push_frame(32'd2500, 32'hDEAD0000);
      n = 0;
      while (!(busy && bit_idx == 48) && n < 20000) begin @(posedge clk); n++; end
      mm_write(1'b0, 8'(RegCtrl), 32'h1);
      for (int i = 0; i < NS; i++) push_frame(3000 + i, 32'hEEEE0000 | i);
      wait_idle();
      chk("rdy_not_early", rdy_cnt, 2);
      push_frame(32'd4000, 32'h0);
      wait_rdy(1'b0, 3, "rdy_third");
      pcm_read(1'b0, 1'b0, 4'd0, 32'd3000);
      pcm_read(1'b0, 1'b0, 4'd15, 32'd3015);
      pcm_read(1'b0, 1'b1, 4'd0, 32'hEEEE0000);
      mm_read(8'(RegStatus), 32'h1);

      // Same-cycle read and clear of FRAME_CNT returns the old count.
      mm_access(1'b0, 1'b1, 1'b1, 8'(RegFrameCnt), 32'h1234, 32'd3);
      mm_read(8'(RegFrameCnt), 32'd0);
      mm_write(1'b0, 8'h3C, 32'h0);
      mm_read(8'(RegCtrl), 32'h1);
      mm_read(8'h3C, 32'h0);
      mm_read(8'h3F, 32'h0);

      wait_idle();
      mm_write(1'b1, 8'(RegCtrl), 32'h1);
      for (int i = 0; i < NS; i++) push_frame(32'h56789ABC, 32'h43218765);
      push_frame(32'h0, 32'h0);
      wait_rdy(1'b1, 1, "rdy16_first");
      pcm_read(1'b1, 1'b0, 4'd0, 32'h56780000);
      pcm_read(1'b1, 1'b1, 4'd7, 32'h43210000);

      repeat (10) @(posedge clk);
      chk("sb_drain", lq.size() + rq.size() + mmq.size() + lq16.size() + rq16.size(), 0);
      chk("rdy_width", rdy_hi, rdy_cnt);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
